// File: rtl/user_obi_timer.sv
// Compare-match timer on a single-outstanding OBI subordinate port.
// Prescaled counter with sticky, maskable match interrupt; one-shot or auto-reload.
module user_obi_timer #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [IdWidth-1:0]   aid_i,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic [IdWidth-1:0]   rid_o,
  output logic                 err_o,
  output logic                 irq_o
);

  localparam logic [2:0]  OffCtrl     = 3'd0;
  localparam logic [2:0]  OffPrescale = 3'd1;
  localparam logic [2:0]  OffCount    = 3'd2;
  localparam logic [2:0]  OffCompare  = 3'd3;
  localparam logic [2:0]  OffStatus   = 3'd4;
  localparam logic [31:0] ErrData     = 32'hBADCAB1E;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

  logic        en_r, ar_r, irqen_r, pending_r;
  logic [15:0] prescale_r, pc_r;
  logic [31:0] count_r, compare_r;
  logic        en_s, ar_s, irqen_s, pending_s;
  logic [15:0] prescale_s, pc_s;
  logic [31:0] count_s, compare_s;

  logic                 rvalid_r, err_r;
  logic [31:0]          rdata_r;
  logic [IdWidth-1:0]   rid_r;

  logic [2:0]  off_s;
  logic        wr_s, tick_s, match_s, mapped_s;
  logic [31:0] rd_data_s, resp_data_s;
  logic        unused_s;

  assign off_s    = addr_i[4:2];
  assign wr_s     = req_i & we_i;
  assign unused_s = ^{addr_i[AddrWidth-1:5], addr_i[1:0]};

  assign tick_s  = en_r & (pc_r == prescale_r);
  assign match_s = tick_s & (count_r == compare_r);

  // Next state of the timer core and the bus-writable registers; bus writes override tick updates
  always_comb begin
    en_s       = en_r;
    ar_s       = ar_r;
    irqen_s    = irqen_r;
    prescale_s = prescale_r;
    count_s    = count_r;
    compare_s  = compare_r;
    pending_s  = pending_r;
    pc_s       = pc_r;

    if (en_r) begin
      pc_s = tick_s ? 16'd0 : (pc_r + 16'd1);
    end else begin
      pc_s = pc_r;
    end

    if (match_s) begin
      pending_s = 1'b1;
      if (ar_r) begin
        count_s = 32'd0;
      end else begin
        count_s = count_r;
        en_s    = 1'b0;
      end
    end else if (tick_s) begin
      count_s = count_r + 32'd1;
    end else begin
      count_s = count_r;
    end

    if (wr_s) begin
      case (off_s)
        OffCtrl: begin
          {irqen_s, ar_s, en_s} = be_i[0] ? wdata_i[2:0] : {irqen_s, ar_s, en_s};
        end
        OffPrescale: begin
          prescale_s = {be_i[1] ? wdata_i[15:8] : prescale_r[15:8],
                        be_i[0] ? wdata_i[7:0]  : prescale_r[7:0]};
          pc_s       = (|be_i) ? 16'd0 : pc_s;
        end
        OffCount: begin
          count_s = (|be_i) ? be_merge(count_r, wdata_i, be_i) : count_s;
        end
        OffCompare: begin
          compare_s = be_merge(compare_r, wdata_i, be_i);
        end
        OffStatus: begin
          // a same-cycle hardware match keeps PENDING set
          pending_s = (be_i[0] & wdata_i[0] & ~match_s) ? 1'b0 : pending_s;
        end
        default: begin
        end
      endcase
    end else begin
      pending_s = pending_s;
    end
  end

  // Read mux and response data selection, sampled from pre-edge register state
  always_comb begin
    rd_data_s = ErrData;
    mapped_s  = 1'b1;
    case (off_s)
      OffCtrl:     rd_data_s = {29'd0, irqen_r, ar_r, en_r};
      OffPrescale: rd_data_s = {16'd0, prescale_r};
      OffCount:    rd_data_s = count_r;
      OffCompare:  rd_data_s = compare_r;
      OffStatus:   rd_data_s = {31'd0, pending_r};
      default: begin
        rd_data_s = ErrData;
        mapped_s  = 1'b0;
      end
    endcase
    if (!mapped_s) begin
      resp_data_s = ErrData;
    end else if (we_i) begin
      resp_data_s = 32'd0;
    end else begin
      resp_data_s = rd_data_s;
    end
  end

  // Register state and the one-cycle response pipeline
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_r       <= 1'b0;
      ar_r       <= 1'b0;
      irqen_r    <= 1'b0;
      pending_r  <= 1'b0;
      prescale_r <= 16'd0;
      pc_r       <= 16'd0;
      count_r    <= 32'd0;
      compare_r  <= 32'd0;
      rvalid_r   <= 1'b0;
      err_r      <= 1'b0;
      rdata_r    <= 32'd0;
      rid_r      <= '0;
    end else begin
      en_r       <= en_s;
      ar_r       <= ar_s;
      irqen_r    <= irqen_s;
      pending_r  <= pending_s;
      prescale_r <= prescale_s;
      pc_r       <= pc_s;
      count_r    <= count_s;
      compare_r  <= compare_s;
      rvalid_r   <= req_i;
      err_r      <= req_i & ~mapped_s;
      rdata_r    <= req_i ? resp_data_s : 32'd0;
      rid_r      <= req_i ? aid_i : rid_r;
    end
  end

  assign gnt_o    = 1'b1;
  assign rvalid_o = rvalid_r;
  assign rdata_o  = rdata_r;
  assign rid_o    = rid_r;
  assign err_o    = err_r;
  assign irq_o    = pending_r & irqen_r;

endmodule

// File: tb/tb_user_obi_timer.sv
// Randomized self-checking bench for user_obi_timer against a cycle-level behavioural model.
module tb_user_obi_timer;

  localparam int IW = 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_i, we_i, gnt_o;
  logic [31:0]   addr_i, wdata_i, rdata_o;
  logic [3:0]    be_i;
  logic [IW-1:0] aid_i, rid_o;
  logic          rvalid_o, err_o, irq_o;

  int n_checks = 0;
  int n_errors = 0;

  // model state: register images as the bus sees them
  logic [31:0]   m_ctrl, m_pre, m_count, m_cmp;
  logic          m_pend;
  int unsigned   m_pc;
  logic          exp_rvalid, exp_err;
  logic [31:0]   exp_rdata;
  logic [IW-1:0] exp_rid;

  user_obi_timer #(.AddrWidth(32), .DataWidth(32), .IdWidth(IW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
    .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .aid_i(aid_i), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .rid_o(rid_o), .err_o(err_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] off);
    case (off)
      3'd0: return m_ctrl;
      3'd1: return m_pre;
      3'd2: return m_count;
      3'd3: return m_cmp;
      3'd4: return {31'd0, m_pend};
      default: return 32'hBADCAB1E;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = 32'd0; m_pre = 32'd0; m_count = 32'd0; m_cmp = 32'd0;
    m_pend = 1'b0; m_pc = 0;
    exp_rvalid = 1'b0; exp_err = 1'b0; exp_rdata = 32'd0; exp_rid = '0;
  endtask

  // one clock edge of the timer as described by its rules
  task automatic model_edge(input logic req, input logic we, input logic [2:0] off,
                            input logic [3:0] be, input logic [31:0] wd, input logic [IW-1:0] id);
    logic tick, hit, npend;
    logic [31:0] nctrl, nctr;
    int unsigned npc;
    exp_rvalid = req;
    if (req) begin
      exp_rid   = id;
      exp_err   = (off > 3'd4);
      exp_rdata = (off > 3'd4) ? 32'hBADCAB1E : (we ? 32'd0 : model_read(off));
    end
    tick  = m_ctrl[0] && (m_pc == m_pre);
    hit   = tick && (m_count == m_cmp);
    nctrl = m_ctrl;
    nctr  = m_count;
    npend = m_pend;
    npc   = m_ctrl[0] ? (tick ? 0 : m_pc + 1) : m_pc;
    if (hit) begin
      npend = 1'b1;
      if (m_ctrl[1]) nctr = 32'd0;
      else nctrl[0] = 1'b0;
    end else if (tick) begin
      nctr = m_count + 32'd1;
    end
    if (req && we && be != 4'd0) begin
      case (off)
        3'd0: if (be[0]) nctrl = wd & 32'h7;
        3'd1: begin m_pre = lane_merge(m_pre, wd, be) & 32'hFFFF; npc = 0; end
        3'd2: nctr = lane_merge(m_count, wd, be);
        3'd3: m_cmp = lane_merge(m_cmp, wd, be);
        3'd4: if (be[0] && wd[0] && !hit) npend = 1'b0;
        default: ;
      endcase
    end
    m_ctrl = nctrl; m_count = nctr; m_pend = npend; m_pc = npc;
  endtask

  // drive one cycle, advance model at the edge, then compare outputs 1 time unit later
  task automatic bus(input logic req, input logic we, input logic [2:0] off,
                     input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] a;
    logic [IW-1:0] id;
    a = $urandom;
    a[4:2] = off;
    id = IW'($urandom);
    req_i = req; we_i = we; addr_i = a; be_i = be; wdata_i = wd; aid_i = id;
    @(posedge clk_i);
    model_edge(req, we, off, be, wd, id);
    #1;
    check_eq("rvalid", {31'd0, rvalid_o}, {31'd0, exp_rvalid});
    if (exp_rvalid) begin
      check_eq("rdata", rdata_o, exp_rdata);
      check_eq("err", {31'd0, err_o}, {31'd0, exp_err});
      check_eq("rid", 32'(rid_o), 32'(exp_rid));
    end
    check_eq("irq", {31'd0, irq_o}, {31'd0, m_ctrl[2] & m_pend});
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] wd);
    bus(1'b1, 1'b1, off, 4'hF, wd);
  endtask

  task automatic rd(input logic [2:0] off);
    bus(1'b1, 1'b0, off, 4'($urandom), 32'($urandom));
  endtask

  task automatic idle();
    bus(1'b0, 1'b0, 3'd0, 4'd0, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rvalid"}, {31'd0, rvalid_o}, 32'd0);
    check_eq({tag, "_rdata"}, rdata_o, 32'd0);
    check_eq({tag, "_rid"}, 32'(rid_o), 32'd0);
    check_eq({tag, "_err"}, {31'd0, err_o}, 32'd0);
    check_eq({tag, "_irq"}, {31'd0, irq_o}, 32'd0);
  endtask

  initial begin
    logic [2:0] off;
    logic [31:0] wd;
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = 32'd0; be_i = 4'd0;
    wdata_i = 32'd0; aid_i = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_outputs("por");
    check_eq("gnt", {31'd0, gnt_o}, 32'd1);
    rst_i = 1'b0;

    // reset values and unmapped offset
    for (int i = 0; i < 6; i++) begin
      rd(3'(i));
      if (i < 5) check_eq("rst_reg", rdata_o, 32'd0);
    end
    check_eq("unmap_data", rdata_o, 32'hBADCAB1E);
    check_eq("unmap_err", {31'd0, err_o}, 32'd1);

    // byte enables and prescale width
    bus(1'b1, 1'b1, 3'd2, 4'b0010, 32'h12345678);
    check_eq("wr_rdata0", rdata_o, 32'd0);
    rd(3'd2);
    check_eq("count_be", rdata_o, 32'h00005600);
    wr(3'd1, 32'hFFFF_0003);
    rd(3'd1);
    check_eq("prescale_w", rdata_o, 32'h00000003);

    // one-shot: irq 5 cycles after CTRL write
    wr(3'd1, 32'd0); wr(3'd2, 32'd0); wr(3'd3, 32'd4); wr(3'd0, 32'h5);
    for (int k = 1; k <= 5; k++) begin
      idle();
      check_eq("oneshot_irq", {31'd0, irq_o}, (k == 5) ? 32'd1 : 32'd0);
    end
    rd(3'd0);
    check_eq("oneshot_ctrl", rdata_o, 32'h4);
    rd(3'd2);
    check_eq("oneshot_cnt", rdata_o, 32'd4);
    wr(3'd4, 32'd1);
    check_eq("w1c_irq", {31'd0, irq_o}, 32'd0);

    // auto-reload: P=2, COMPARE=1
    wr(3'd0, 32'd0); wr(3'd1, 32'd2); wr(3'd2, 32'd0); wr(3'd3, 32'd1); wr(3'd0, 32'h7);
    for (int k = 1; k <= 12; k++) begin
      if (k == 7) begin
        wr(3'd4, 32'd1);
      end else begin
        rd(3'd2);
        check_eq("ar_count", rdata_o, 32'(((k - 1) / 3) % 2));
      end
      check_eq("ar_irq", {31'd0, irq_o}, (k == 6 || k == 12) ? 32'd1 : 32'd0);
    end

    // wrap without match, then match at 5
    wr(3'd0, 32'd0); wr(3'd2, 32'hFFFF_FFFF); wr(3'd3, 32'd5); wr(3'd1, 32'd0);
    wr(3'd4, 32'd1); wr(3'd0, 32'd1);
    idle();
    rd(3'd2);
    check_eq("wrap_cnt", rdata_o, 32'd0);
    rd(3'd4);
    check_eq("wrap_nopend", rdata_o, 32'd0);
    repeat (4) idle();
    rd(3'd4);
    check_eq("wrap_pend", rdata_o, 32'd1);
    rd(3'd2);
    check_eq("wrap_hold", rdata_o, 32'd5);

    // W1C on the matching edge loses to the hardware set
    wr(3'd4, 32'd1); wr(3'd2, 32'd0); wr(3'd3, 32'd2); wr(3'd0, 32'd1);
    idle(); idle();
    wr(3'd4, 32'd1);
    rd(3'd4);
    check_eq("w1c_race", rdata_o, 32'd1);

    // reset while running with a response in flight
    wr(3'd3, 32'hFFFF_FFFF); wr(3'd0, 32'h7);
    idle(); idle();
    rd(3'd2);
    #2;
    req_i = 1'b0;
    rst_i = 1'b1;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    idle();
    for (int i = 0; i < 5; i++) begin
      rd(3'(i));
      check_eq("post_rst", rdata_o, 32'd0);
    end

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      off = 3'($urandom_range(0, 7));
      case (off)
        3'd0: wd = {$urandom} & 32'hFFFF_FF07 | ((($urandom % 4) == 0) ? 32'h0 : 32'h1);
        3'd1: wd = 32'($urandom_range(0, 3));
        3'd2: wd = (($urandom % 8) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 8));
        3'd3: wd = 32'($urandom_range(0, 12));
        default: wd = $urandom;
      endcase
      if (($urandom % 4) == 0) idle();
      else bus(1'b1, 1'($urandom), off, (($urandom % 2) == 0) ? 4'hF : 4'($urandom), wd);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
